div3_seq_driver: RTL and testbench



---
 rtl/div3_seq_driver_pkg.sv | 17 +
 rtl/div3_seq_driver_ref_counter.sv | 55 +++++
 rtl/div3_seq_driver.sv | 121 ++++++++++++
 tb/tb_div3_seq_driver.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_seq_driver_pkg.sv
// Shared types and helpers for the div3 sequence driver and its reference counter.
package div3_seq_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_PASS,
    ST_FAIL
  } state_t;

  // Quotient width of an N-bit divide-by-3.
  function automatic int qw(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/div3_seq_driver_ref_counter.sv
// Operand counter that tracks x/3 and x%3 incrementally, so 3*q + r == x always holds.
module div3_seq_driver_ref_counter
  import div3_seq_driver_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [N-1:0]       x_o,
  output logic [qw(N)-1:0]   q_o,
  output logic               last_o
);

  logic [N-1:0]     x_q, x_d;
  logic [qw(N)-1:0] q_q, q_d;
  logic [1:0]       r_q, r_d;

  always_comb begin
    x_d = x_q;
    q_d = q_q;
    r_d = r_q;
    if (clr_i) begin
      x_d = '0;
      q_d = '0;
      r_d = '0;
    end else if (inc_i) begin
      x_d = x_q + 1'b1;
      if (r_q == 2'd2) begin
        r_d = '0;
        q_d = q_q + 1'b1;
      end else begin
        r_d = r_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      x_q <= x_d;
      q_q <= q_d;
      r_q <= r_d;
    end
  end

  assign x_o    = x_q;
  assign q_o    = q_q;
  assign last_o = (x_q == '1);

endmodule

// File: rtl/div3_seq_driver.sv
// Built-in self-test initiator: sweeps every operand through a div3 responder and checks each quotient.
module div3_seq_driver
  import div3_seq_driver_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic [N-1:0]       o_x,
  output logic               o_vld,
  input  logic [qw(N)-1:0]   i_y,
  input  logic               i_vld,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [N-1:0]       o_err_x,
  output logic [qw(N)-1:0]   o_err_y
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
  logic [N-1:0]     err_x_q, err_x_d;
  logic [qw(N)-1:0] err_y_q, err_y_d;

  logic             clr, inc, last;
  logic [N-1:0]     x;
  logic [qw(N)-1:0] q;

  div3_seq_driver_ref_counter #(.N(N)) u_ref (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (inc),
    .x_o    (x),
    .q_o    (q),
    .last_o (last)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    err_x_d   = err_x_q;
    err_y_d   = err_y_q;
    clr       = 1'b0;
    inc       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (i_start) begin
          state_d   = ST_SEND;
          clr       = 1'b1;
          tmo_d     = '0;
          timeout_d = 1'b0;
          err_x_d   = '0;
          err_y_d   = '0;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (i_vld) begin
          if (i_y == q) begin
            if (last) begin
              state_d = ST_PASS;
            end else begin
              inc     = 1'b1;
              state_d = ST_SEND;
            end
          end else begin
            state_d = ST_FAIL;
            err_x_d = x;
            err_y_d = i_y;
          end
        // The incremented count reaching TIMEOUT-1 ends the wait, so FAIL lands TIMEOUT cycles after o_vld.
        end else if (tmo_q == TW'(TIMEOUT - 2)) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
          err_x_d   = x;
          err_y_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      err_x_q   <= '0;
      err_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      err_x_q   <= err_x_d;
      err_y_q   <= err_y_d;
    end
  end

  assign o_x       = x;
  assign o_vld     = (state_q == ST_SEND);
  assign o_busy    = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign o_done    = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign o_pass    = (state_q == ST_PASS);
  assign o_timeout = timeout_q;
  assign o_err_x   = err_x_q;
  assign o_err_y   = err_y_q;

endmodule

// File: tb/tb_div3_seq_driver.sv
// Bench for div3_seq_driver: a behavioural div3 responder with random latency plus outcome checks.
module tb_div3_seq_driver;

  localparam int N   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [N-1:0] o_x;
  logic         o_vld;
  logic [N-2:0] i_y;
  logic         i_vld;
  logic         o_busy, o_done, o_pass, o_timeout;
  logic [N-1:0] o_err_x;
  logic [N-2:0] o_err_y;

  // Responder and spurious-injection drive paths, merged onto the DUT inputs.
  logic         resp_vld = 1'b0;
  logic [N-2:0] resp_y = '0;
  logic         spur_vld = 1'b0;
  logic [N-2:0] spur_y = '0;
  assign i_vld = resp_vld | spur_vld;
  assign i_y   = spur_vld ? spur_y : resp_y;

  int checks = 0;
  int failures = 0;

  // Responder behaviour: 0 correct, 1 wrong answer at x=100, 2 silent.
  int resp_mode = 0;
  int ovr_en = 0;
  int ovr_x = 0;
  int ovr_lat = 0;

  // Monitor model: expected next operand and pulse count.
  int mon_exp = 0;
  int mon_cnt = 0;

  div3_seq_driver #(.N(N), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .o_x       (o_x),
    .o_vld     (o_vld),
    .i_y       (i_y),
    .i_vld     (i_vld),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_pass    (o_pass),
    .o_timeout (o_timeout),
    .o_err_x   (o_err_x),
    .o_err_y   (o_err_y)
  );

  always #5 clk = ~clk;

  // Registered responder: answers L cycles after sampling the operand pulse (L>=1).
  initial begin : responder
    int pending;
    int cnt;
    int lat;
    int cap_x;
    pending = 0;
    cnt = 0;
    lat = 1;
    cap_x = 0;
    forever begin
      @(negedge clk);
      resp_vld = 1'b0;
      if (!rst_n) begin
        pending = 0;
      end else if (pending != 0) begin
        if (cnt == lat) begin
          resp_vld = 1'b1;
          resp_y   = (resp_mode == 1 && cap_x == 100) ? 7'd35 : 7'(cap_x / 3);
          pending  = 0;
        end else begin
          cnt++;
        end
      end else if (o_vld && resp_mode != 2) begin
        cap_x   = int'(o_x);
        lat     = (ovr_en != 0 && cap_x == ovr_x) ? ovr_lat : int'($urandom_range(8, 1));
        cnt     = 1;
        pending = 1;
      end
    end
  end

  // Every operand pulse must carry the next operand in sequence.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && o_vld) begin
        checks++;
        if (o_x !== N'(mon_exp)) begin
          failures++;
          $display("FAIL op_seq: o_x=%0d required %0d", o_x, mon_exp);
        end
        mon_exp++;
        mon_cnt++;
      end
    end
  end

  task automatic pulse_start();
    mon_exp = 0;
    mon_cnt = 0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cycles(3);
    checks++;
    if ({o_x, o_vld, o_busy, o_done, o_pass, o_timeout, o_err_x, o_err_y} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: x=%0d vld=%b busy=%b done=%b pass=%b tmo=%b ex=%0d ey=%0d required all 0",
               o_x, o_vld, o_busy, o_done, o_pass, o_timeout, o_err_x, o_err_y);
    end
    rst_n = 1'b1;
    idle_cycles(2);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic check_pass_result(input string tag);
    checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_flags: done=%b pass=%b tmo=%b busy=%b required 1 1 0 0",
               tag, o_done, o_pass, o_timeout, o_busy);
    end
    checks++;
    if (mon_cnt != 256) begin
      failures++;
      $display("FAIL %s_pulses: count=%0d required 256", tag, mon_cnt);
    end
    checks++;
    if (o_err_x !== '0 || o_err_y !== '0) begin
      failures++;
      $display("FAIL %s_err: ex=%0d ey=%0d required 0 0", tag, o_err_x, o_err_y);
    end
  endtask

  task automatic run_sweep(input string tag);
    bit ok;
    pulse_start();
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0 || o_vld !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: busy=%b done=%b pass=%b vld=%b required 1 0 0 1",
               tag, o_busy, o_done, o_pass, o_vld);
    end
    wait_done(12000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_budget: done=%b required 1 within budget", tag, o_done);
    end
    check_pass_result(tag);
  endtask

  task automatic test_full_sweep();
    resp_mode = 0;
    ovr_en = 0;
    run_sweep("sweep");
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b");
  endtask

  task automatic test_fault();
    bit ok;
    resp_mode = 1;
    pulse_start();
    wait_done(12000, ok);
    checks++;
    if (!ok || o_pass !== 1'b0 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL fault_flags: ok=%0d pass=%b tmo=%b required 1 0 0", ok, o_pass, o_timeout);
    end
    checks++;
    if (o_err_x !== 8'd100 || o_err_y !== 7'd35) begin
      failures++;
      $display("FAIL fault_err: ex=%0d ey=%0d required 100 35", o_err_x, o_err_y);
    end
    idle_cycles(100);
    checks++;
    if (mon_cnt != 101 || o_done !== 1'b1) begin
      failures++;
      $display("FAIL fault_no_more: pulses=%0d done=%b required 101 1", mon_cnt, o_done);
    end
    resp_mode = 0;
  endtask

  task automatic test_timeout();
    int gap;
    resp_mode = 2;
    pulse_start();
    // pulse_start returns at the negedge of the first operand-valid cycle.
    gap = 0;
    while (!o_done && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap != TMO) begin
      failures++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", gap, TMO);
    end
    checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b0 || o_timeout !== 1'b1 ||
        o_err_x !== '0 || o_err_y !== '0) begin
      failures++;
      $display("FAIL timeout_flags: done=%b pass=%b tmo=%b ex=%0d ey=%0d required 1 0 1 0 0",
               o_done, o_pass, o_timeout, o_err_x, o_err_y);
    end
    checks++;
    if (mon_cnt != 1) begin
      failures++;
      $display("FAIL timeout_pulses: count=%0d required 1", mon_cnt);
    end
    resp_mode = 0;
  endtask

  task automatic test_latency_boundary();
    bit ok;
    // Slowest accepted response: lands on the last wait cycle.
    ovr_en = 1;
    ovr_x = 5;
    ovr_lat = TMO - 1;
    run_sweep("lat_max");
    // One cycle later the driver has already given up.
    ovr_x = 7;
    ovr_lat = TMO;
    pulse_start();
    wait_done(12000, ok);
    checks++;
    if (!ok || o_pass !== 1'b0 || o_timeout !== 1'b1 || o_err_x !== 8'd7 || o_err_y !== '0) begin
      failures++;
      $display("FAIL lat_over: ok=%0d pass=%b tmo=%b ex=%0d ey=%0d required 1 0 1 7 0",
               ok, o_pass, o_timeout, o_err_x, o_err_y);
    end
    idle_cycles(TMO + 10);
    checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b1 || mon_cnt != 8) begin
      failures++;
      $display("FAIL lat_over_hold: done=%b tmo=%b pulses=%0d required 1 1 8", o_done, o_timeout, mon_cnt);
    end
    ovr_en = 0;
  endtask

  task automatic test_spurious();
    bit ok;
    logic [N-1:0] ex_before;
    ex_before = o_err_x;
    @(negedge clk);
    spur_vld = 1'b1;
    spur_y = 7'($urandom_range(127, 0));
    @(negedge clk);
    spur_vld = 1'b0;
    idle_cycles(2);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b1 || o_err_x !== ex_before) begin
      failures++;
      $display("FAIL spur_idle: busy=%b done=%b ex=%0d required 0 1 %0d", o_busy, o_done, o_err_x, ex_before);
    end
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      spur_vld = 1'b0;
      i_start = 1'b0;
      if (o_vld && $urandom_range(3, 0) == 0) begin
        spur_vld = 1'b1;
        spur_y = 7'(int'(o_x) / 3 + 1);
      end else if (o_busy && !o_vld && $urandom_range(7, 0) == 0) begin
        i_start = 1'b1;
      end
      @(negedge clk);
    end
    spur_vld = 1'b0;
    i_start = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL spur_budget: done=%b required 1 within budget", o_done);
    end
    check_pass_result("spur");
  endtask

  task automatic test_reset_midrun();
    bit ok;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (o_busy && !o_vld && o_x == 8'd57) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrun_reach: x=%0d required 57 in wait", o_x);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_x, o_vld, o_busy, o_done, o_pass, o_timeout, o_err_x, o_err_y} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: x=%0d vld=%b busy=%b done=%b pass=%b required all 0",
               o_x, o_vld, o_busy, o_done, o_pass);
    end
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    run_sweep("restart");
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_back_to_back();
    test_fault();
    test_timeout();
    test_latency_boundary();
    test_spurious();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
